// File: rtl/cc_fill_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cc_fill_ctrl
// Purpose  : Per-request sequencer for a direct-mapped cache: serves hits and
//            runs the miss -> burst read -> data/tag fill -> replay sequence.
// Revision : 1.0 - initial release
// ============================================================================
module cc_fill_ctrl #(
    parameter int BEATS = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             hs_pulse_i,
    input  logic             hit_i,
    input  logic             miss_i,
    input  logic [16:0]      tag_delayed_i,
    input  logic [8:0]       index_delayed_i,
    output logic             busy_o,
    output logic             hit_done_o,
    output logic             fill_done_o,
    output logic             mem_arvalid_o,
    input  logic             mem_arready_i,
    output logic [31:0]      mem_araddr_o,
    output logic [3:0]       mem_arlen_o,
    input  logic             mem_rvalid_i,
    output logic             mem_rready_o,
    input  logic [63:0]      mem_rdata_i,
    input  logic             mem_rlast_i,
    output logic             data_wren_o,
    output logic [11:0]      data_waddr_o,
    output logic [63:0]      data_wdata_o,
    output logic             tag_wren_o,
    output logic [8:0]       tag_waddr_o,
    output logic [17:0]      tag_wdata_o,
    output logic             fill_err_o,
    output logic [CNT_W-1:0] miss_cnt_o
);

    localparam logic [2:0] c_last_beat = 3'(BEATS - 1);
    localparam logic [3:0] c_arlen     = 4'(BEATS - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOOKUP = 3'd1,
        ST_REQ    = 3'd2,
        ST_FILL   = 3'd3,
        ST_TAG_WR = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    state_t           state_q,    state_d;
    logic [2:0]       cnt_q,      cnt_d;
    logic [16:0]      tag_q,      tag_d;
    logic [8:0]       index_q,    index_d;
    logic             err_q,      err_d;
    logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 3'd0;
            tag_q      <= 17'd0;
            index_q    <= 9'd0;
            err_q      <= 1'b0;
            miss_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            tag_q      <= tag_d;
            index_q    <= index_d;
            err_q      <= err_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        tag_d         = tag_q;
        index_d       = index_q;
        err_d         = err_q;
        miss_cnt_d    = miss_cnt_q;
        hit_done_o    = 1'b0;
        fill_done_o   = 1'b0;
        mem_arvalid_o = 1'b0;
        mem_rready_o  = 1'b0;
        data_wren_o   = 1'b0;
        data_wdata_o  = 64'd0;
        tag_wren_o    = 1'b0;
        tag_wdata_o   = 18'd0;

        case (state_q)
            ST_IDLE: begin
                if (hs_pulse_i) begin
                    state_d = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                // A simultaneous hit and miss resolves as a hit; neither is a
                // protocol error that quietly drops the request.
                if (hit_i) begin
                    hit_done_o = 1'b1;
                    state_d    = ST_IDLE;
                end else if (miss_i) begin
                    tag_d   = tag_delayed_i;
                    index_d = index_delayed_i;
                    if (miss_cnt_q != '1) begin
                        miss_cnt_d = miss_cnt_q + CNT_W'(1);
                    end
                    state_d = ST_REQ;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                mem_arvalid_o = 1'b1;
                if (mem_arready_i) begin
                    state_d = ST_FILL;
                end
            end
            ST_FILL: begin
                mem_rready_o = 1'b1;
                if (mem_rvalid_i) begin
                    data_wren_o  = 1'b1;
                    data_wdata_o = mem_rdata_i;
                    cnt_d        = cnt_q + 3'd1;
                    // rlast is only a consistency check; beat counting alone
                    // decides where the line ends.
                    if (mem_rlast_i != (cnt_q == c_last_beat)) begin
                        err_d = 1'b1;
                    end
                    if (cnt_q == c_last_beat) begin
                        cnt_d   = 3'd0;
                        state_d = ST_TAG_WR;
                    end
                end
            end
            ST_TAG_WR: begin
                tag_wren_o  = 1'b1;
                tag_wdata_o = {1'b1, tag_q};
                state_d     = ST_DONE;
            end
            ST_DONE: begin
                fill_done_o = 1'b1;
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy_o       = (state_q != ST_IDLE);
    assign mem_araddr_o = {tag_q, index_q, 6'd0};
    assign mem_arlen_o  = c_arlen;
    assign data_waddr_o = {index_q, cnt_q};
    assign tag_waddr_o  = index_q;
    assign fill_err_o   = err_q;
    assign miss_cnt_o   = miss_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_cc_fill_ctrl.sv
`default_nettype none
// Bench for cc_fill_ctrl: directed requests, queued expected events, and a
// monitor comparing every DUT output event against the queue head.
module tb_cc_fill_ctrl;

    localparam int EV_AR = 0;
    localparam int EV_DW = 1;
    localparam int EV_TW = 2;
    localparam int EV_HD = 3;
    localparam int EV_FD = 4;

    typedef struct {
        int          kind;
        logic [31:0] a;
        logic [63:0] d;
    } ev_t;

    ev_t ev_q[$];
    int  total = 0;
    int  bad   = 0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        hs_pulse_i = 1'b0, hit_i = 1'b0, miss_i = 1'b0;
    logic [16:0] tag_delayed_i = '0;
    logic [8:0]  index_delayed_i = '0;
    logic        mem_arready_i = 1'b0, mem_rvalid_i = 1'b0, mem_rlast_i = 1'b0;
    logic [63:0] mem_rdata_i = '0;

    logic        busy_o, hit_done_o, fill_done_o, mem_arvalid_o, mem_rready_o;
    logic [31:0] mem_araddr_o;
    logic [3:0]  mem_arlen_o;
    logic        data_wren_o, tag_wren_o, fill_err_o;
    logic [11:0] data_waddr_o;
    logic [63:0] data_wdata_o;
    logic [8:0]  tag_waddr_o;
    logic [17:0] tag_wdata_o;
    logic [15:0] miss_cnt_o;

    logic        d2_busy, d2_hd, d2_fd, d2_arvalid, d2_rready, d2_wren, d2_twren, d2_err;
    logic [31:0] d2_araddr;
    logic [3:0]  d2_arlen;
    logic [11:0] d2_waddr;
    logic [63:0] d2_wdata;
    logic [8:0]  d2_twaddr;
    logic [17:0] d2_twdata;
    logic [1:0]  d2_miss_cnt;

    always #5 clk = ~clk;

    cc_fill_ctrl #(.BEATS(8), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .hs_pulse_i(hs_pulse_i), .hit_i(hit_i), .miss_i(miss_i),
        .tag_delayed_i(tag_delayed_i), .index_delayed_i(index_delayed_i),
        .busy_o(busy_o), .hit_done_o(hit_done_o), .fill_done_o(fill_done_o),
        .mem_arvalid_o(mem_arvalid_o), .mem_arready_i(mem_arready_i),
        .mem_araddr_o(mem_araddr_o), .mem_arlen_o(mem_arlen_o),
        .mem_rvalid_i(mem_rvalid_i), .mem_rready_o(mem_rready_o),
        .mem_rdata_i(mem_rdata_i), .mem_rlast_i(mem_rlast_i),
        .data_wren_o(data_wren_o), .data_waddr_o(data_waddr_o), .data_wdata_o(data_wdata_o),
        .tag_wren_o(tag_wren_o), .tag_waddr_o(tag_waddr_o), .tag_wdata_o(tag_wdata_o),
        .fill_err_o(fill_err_o), .miss_cnt_o(miss_cnt_o)
    );

    // Narrow-counter twin sharing the same stimulus, so saturation is reached
    // after only three misses.
    cc_fill_ctrl #(.BEATS(8), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .hs_pulse_i(hs_pulse_i), .hit_i(hit_i), .miss_i(miss_i),
        .tag_delayed_i(tag_delayed_i), .index_delayed_i(index_delayed_i),
        .busy_o(d2_busy), .hit_done_o(d2_hd), .fill_done_o(d2_fd),
        .mem_arvalid_o(d2_arvalid), .mem_arready_i(mem_arready_i),
        .mem_araddr_o(d2_araddr), .mem_arlen_o(d2_arlen),
        .mem_rvalid_i(mem_rvalid_i), .mem_rready_o(d2_rready),
        .mem_rdata_i(mem_rdata_i), .mem_rlast_i(mem_rlast_i),
        .data_wren_o(d2_wren), .data_waddr_o(d2_waddr), .data_wdata_o(d2_wdata),
        .tag_wren_o(d2_twren), .tag_waddr_o(d2_twaddr), .tag_wdata_o(d2_twdata),
        .fill_err_o(d2_err), .miss_cnt_o(d2_miss_cnt)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic push(input int kind, input logic [31:0] a, input logic [63:0] d);
        ev_t e;
        e.kind = kind;
        e.a    = a;
        e.d    = d;
        ev_q.push_back(e);
    endtask

    task automatic take(input int kind, input logic [31:0] a, input logic [63:0] d);
        ev_t e;
        if (ev_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_event: got kind %0d addr %h data %h expected none", kind, a, d);
        end else begin
            e = ev_q.pop_front();
            chk("ev_kind", 64'(kind), 64'(e.kind));
            if (kind == e.kind) begin
                chk("ev_addr", 64'(a), 64'(e.a));
                chk("ev_data", d, e.d);
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_arvalid_o && mem_arready_i) take(EV_AR, mem_araddr_o, 64'd0);
            if (data_wren_o) take(EV_DW, 32'(data_waddr_o), data_wdata_o);
            if (tag_wren_o)  take(EV_TW, 32'(tag_waddr_o), 64'(tag_wdata_o));
            if (hit_done_o)  take(EV_HD, 32'd0, 64'd0);
            if (fill_done_o) take(EV_FD, 32'd0, 64'd0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_hit();
        tick();
        hs_pulse_i = 1'b1;
        tick();
        hs_pulse_i = 1'b0;
        hit_i      = 1'b1;
        push(EV_HD, 32'd0, 64'd0);
        @(negedge clk);
        chk("hit_busy", 64'(busy_o), 64'd1);
        chk("hit_no_arvalid", 64'(mem_arvalid_o), 64'd0);
        tick();
        hit_i = 1'b0;
        @(negedge clk);
        chk("hit_busy_after", 64'(busy_o), 64'd0);
    endtask

    task automatic do_miss(input logic [16:0] tag, input logic [8:0] idx, input int arwait,
                           input int gap, input int rlast_pos, input bit hs_in_fill,
                           input logic [63:0] dbase);
        logic [31:0] araddr;
        araddr = {tag, idx, 6'd0};
        push(EV_AR, araddr, 64'd0);
        for (int b = 0; b < 8; b++) push(EV_DW, 32'({idx, 3'(b)}), dbase + 64'(b));
        push(EV_TW, 32'(idx), 64'({1'b1, tag}));
        push(EV_FD, 32'd0, 64'd0);
        tick();
        hs_pulse_i = 1'b1;
        tick();
        hs_pulse_i      = 1'b0;
        miss_i          = 1'b1;
        tag_delayed_i   = tag;
        index_delayed_i = idx;
        tick();
        miss_i = 1'b0;
        for (int w = 0; w <= arwait; w++) begin
            mem_arready_i = (w == arwait);
            @(negedge clk);
            chk("arvalid_held", 64'(mem_arvalid_o), 64'd1);
            chk("araddr_stable", 64'(mem_araddr_o), 64'(araddr));
            tick();
        end
        mem_arready_i = 1'b0;
        for (int b = 0; b < 8; b++) begin
            for (int g = 0; g < gap; g++) begin
                mem_rvalid_i = 1'b0;
                hs_pulse_i   = hs_in_fill && (b == 2) && (g == 0);
                tick();
            end
            hs_pulse_i   = 1'b0;
            hit_i        = hs_in_fill && (b == 2);
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = dbase + 64'(b);
            mem_rlast_i  = (b == rlast_pos);
            tick();
            hit_i = 1'b0;
        end
        mem_rvalid_i = 1'b0;
        mem_rlast_i  = 1'b0;
        tick();
        tick();
        @(negedge clk);
        chk("miss_idle_after", 64'(busy_o), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ctl", 64'({busy_o, hit_done_o, fill_done_o, mem_arvalid_o, mem_rready_o,
                            data_wren_o, tag_wren_o, fill_err_o}), 64'd0);
        chk("rst_arlen", 64'(mem_arlen_o), 64'd7);
        chk("rst_misscnt", 64'(miss_cnt_o), 64'd0);
        tick();
        rst_n = 1'b1;

        // Hit path.
        do_hit();
        chk("hit_misscnt", 64'(miss_cnt_o), 64'd0);

        // Nominal miss, address held off three cycles.
        do_miss(17'h1ABCD, 9'h055, 3, 0, 7, 1'b0, 64'd0);
        chk("m1_misscnt", 64'(miss_cnt_o), 64'd1);
        chk("m1_err", 64'(fill_err_o), 64'd0);

        // Beats every other cycle, stray request mid-fill.
        do_miss(17'h00F0F, 9'h1C3, 0, 1, 7, 1'b1, 64'hA5A5_0000_0000_1000);
        chk("m2_misscnt", 64'(miss_cnt_o), 64'd2);
        chk("m2_err", 64'(fill_err_o), 64'd0);

        // rlast on the fifth beat.
        do_miss(17'h12345, 9'h0FF, 1, 0, 4, 1'b0, 64'h1111_2222_3333_0000);
        chk("m3_err", 64'(fill_err_o), 64'd1);
        chk("m3_misscnt", 64'(miss_cnt_o), 64'd3);
        chk("m3_sat_cnt", 64'(d2_miss_cnt), 64'd3);

        // Clean miss after error: error sticky, narrow counter saturated.
        do_miss(17'h0_0001, 9'h000, 0, 0, 7, 1'b0, 64'hFFFF_FFFF_FFFF_FFF0);
        chk("m4_err_sticky", 64'(fill_err_o), 64'd1);
        chk("m4_misscnt", 64'(miss_cnt_o), 64'd4);
        chk("m4_sat_hold", 64'(d2_miss_cnt), 64'd3);

        // Reset in the middle of a fill after three beats.
        push(EV_AR, {17'h0AAAA, 9'h111, 6'd0}, 64'd0);
        for (int b = 0; b < 3; b++) push(EV_DW, 32'({9'h111, 3'(b)}), 64'hC0 + 64'(b));
        tick();
        hs_pulse_i = 1'b1;
        tick();
        hs_pulse_i      = 1'b0;
        miss_i          = 1'b1;
        tag_delayed_i   = 17'h0AAAA;
        index_delayed_i = 9'h111;
        tick();
        miss_i        = 1'b0;
        mem_arready_i = 1'b1;
        tick();
        mem_arready_i = 1'b0;
        for (int b = 0; b < 4; b++) begin
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = 64'hC0 + 64'(b);
            if (b < 3) tick();
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_ctl", 64'({busy_o, hit_done_o, fill_done_o, mem_arvalid_o, mem_rready_o,
                             data_wren_o, tag_wren_o, fill_err_o}), 64'd0);
        chk("arst_araddr", 64'(mem_araddr_o), 64'd0);
        chk("arst_wdata", data_wdata_o, 64'd0);
        chk("arst_addrs", 64'({data_waddr_o, tag_waddr_o, tag_wdata_o}), 64'd0);
        chk("arst_misscnt", 64'(miss_cnt_o), 64'd0);
        chk("arst_arlen", 64'(mem_arlen_o), 64'd7);
        tick();
        mem_rvalid_i = 1'b0;
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_idle", 64'(busy_o), 64'd0);
        do_hit();
        chk("post_rst_misscnt", 64'(miss_cnt_o), 64'd0);

        repeat (3) tick();
        chk("queue_empty", 64'(ev_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
